// File: rtl/eer_pkt_pkg.sv
// Shared packet definitions for the EER-RL node: packet type codes,
// per-type lengths, header field positions and the transmit FSM states.
package eer_pkt_pkg;

   localparam logic [2:0] PKT_HB    = 3'b000;
   localparam logic [2:0] PKT_CHE   = 3'b001;
   localparam logic [2:0] PKT_CH_TS = 3'b100;
   localparam logic [2:0] PKT_DATA  = 3'b101;
   localparam logic [2:0] PKT_SOS   = 3'b110;

   localparam logic [7:0] LEN_HB    = 8'd4;
   localparam logic [7:0] LEN_CHE   = 8'd5;
   localparam logic [7:0] LEN_CH_TS = 8'd4;
   localparam logic [7:0] LEN_DATA  = 8'd5;
   localparam logic [7:0] LEN_SOS   = 8'd4;

   // Header word layout: {type[2:0], 5'b0, len[7:0]}
   localparam int HDR_TYPE_MSB = 15;
   localparam int HDR_TYPE_LSB = 13;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_SLOT = 2'd1,
      ST_SEND      = 2'd2
   } tx_state_t;

   function automatic logic type_supported(input logic [2:0] t);
      case (t)
         PKT_HB, PKT_CHE, PKT_CH_TS, PKT_DATA, PKT_SOS: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

   // Total packet length in words, 0 for unsupported types
   function automatic logic [7:0] pkt_len(input logic [2:0] t);
      case (t)
         PKT_HB:    return LEN_HB;
         PKT_CHE:   return LEN_CHE;
         PKT_CH_TS: return LEN_CH_TS;
         PKT_DATA:  return LEN_DATA;
         PKT_SOS:   return LEN_SOS;
         default:   return 8'd0;
      endcase
   endfunction

   function automatic logic [15:0] build_header(input logic [2:0] t, input logic [7:0] len);
      logic [15:0] h;
      h = '0;
      h[HDR_TYPE_MSB:HDR_TYPE_LSB] = t;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      return h;
   endfunction

   // Hop count advertised to neighbours; the unreachable marker FFFF stays put
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pkt_tx_builder_if.sv
// Transmit request channel plus outgoing word stream.
// Stream handshake: a word transfers on a clock edge where tx_valid and
// tx_ready are both high; once tx_valid rises, it and tx_word/tx_last hold
// steady until that transfer happens. tx_ready may change freely.
interface pkt_tx_builder_if;

   logic        tx_req;
   logic [2:0]  tx_pkt_type;
   logic [15:0] tx_dest_id;
   logic [15:0] tx_payload;
   logic        tx_ack;
   logic        tx_err;
   logic        tx_busy;
   logic        tx_done;
   logic [15:0] tx_word;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;

   // Packet builder side: takes requests, drives the word stream
   modport master (
      input  tx_req, tx_pkt_type, tx_dest_id, tx_payload, tx_ready,
      output tx_ack, tx_err, tx_busy, tx_done, tx_word, tx_valid, tx_last
   );

   // Requester / stream consumer side
   modport slave (
      output tx_req, tx_pkt_type, tx_dest_id, tx_payload, tx_ready,
      input  tx_ack, tx_err, tx_busy, tx_done, tx_word, tx_valid, tx_last
   );

endinterface

// File: rtl/slot_timer.sv
// TDMA slot timer: cyc_cnt runs 0..SLOT_CYCLES-1, slot_cnt counts wraps.
// frame_start restarts the round and wins over the increment.
module slot_timer #(
   parameter int SLOT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        frame_start,
   output logic [15:0] slot_cnt
);

   localparam int            CW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

   logic [CW-1:0] cyc_cnt;

   // Cycle and slot counters, cleared at the start of every round
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cyc_cnt  <= '0;
         slot_cnt <= '0;
      end else if (frame_start) begin
         cyc_cnt  <= '0;
         slot_cnt <= '0;
      end else if (cyc_cnt == CYC_LAST) begin
         cyc_cnt  <= '0;
         slot_cnt <= slot_cnt + 16'd1;
      end else begin
         cyc_cnt  <= cyc_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pkt_tx_builder.sv
// Transmit-side packet assembler: snapshots a request into a word buffer,
// optionally holds member DATA packets until the node's TDMA slot, then
// streams the packet one word per accepted handshake.
module pkt_tx_builder
   import eer_pkt_pkg::*;
#(
   parameter int SLOT_CYCLES = 64,
   parameter int WORD_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   pkt_tx_builder_if.master      bus,
   input  logic [15:0]           myNodeID,
   input  logic [15:0]           hopsFromSink,
   input  logic [15:0]           myQValue,
   input  logic [15:0]           energy,
   input  logic [15:0]           timeslot,
   input  logic                  role,
   input  logic                  frame_start,
   output tx_state_t             dbg_state
);

   tx_state_t             state_q, state_d;
   logic [15:0]           slot_cnt;
   logic [WORD_WIDTH-1:0] w0_q, w1_q, w2_q, w3_q, w4_q;
   logic [WORD_WIDTH-1:0] w3_d, w4_d, word_d;
   logic [7:0]            len_q;
   logic [2:0]            idx_q;
   logic [15:0]           ts_q;
   logic                  ack_q, err_q, done_q;
   logic                  req_ok, req_bad, gate, valid, hs, is_last;

   slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_slot_timer (
      .clk         (clk),
      .nrst        (nrst),
      .frame_start (frame_start),
      .slot_cnt    (slot_cnt)
   );

   assign req_ok  = (state_q == ST_IDLE) && bus.tx_req &&  type_supported(bus.tx_pkt_type);
   assign req_bad = (state_q == ST_IDLE) && bus.tx_req && !type_supported(bus.tx_pkt_type);
   // Only member DATA packets outside their own slot have to wait
   assign gate    = (bus.tx_pkt_type == PKT_DATA) && !role && (slot_cnt != timeslot);
   assign valid   = (state_q == ST_SEND);
   assign hs      = valid && bus.tx_ready;
   assign is_last = (({5'b0, idx_q} + 8'd1) == len_q);

   // Type-specific trailing fields, captured at acceptance
   always_comb begin
      w3_d = '0;
      w4_d = '0;
      case (bus.tx_pkt_type)
         PKT_HB:    w3_d = sat_inc(hopsFromSink);
         PKT_CHE:   begin w3_d = myQValue; w4_d = energy; end
         PKT_CH_TS: w3_d = bus.tx_payload;
         PKT_DATA:  begin w3_d = hopsFromSink; w4_d = bus.tx_payload; end
         PKT_SOS:   w3_d = energy;
         default:   ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (req_ok) state_d = gate ? ST_WAIT_SLOT : ST_SEND;
         ST_WAIT_SLOT: if (slot_cnt == ts_q) state_d = ST_SEND;
         ST_SEND:      if (hs && is_last) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Snapshot buffer, word index and one-cycle status pulses
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         w0_q   <= '0;
         w1_q   <= '0;
         w2_q   <= '0;
         w3_q   <= '0;
         w4_q   <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         ts_q   <= '0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         ack_q  <= req_ok;
         err_q  <= req_bad;
         done_q <= hs && is_last;
         if (req_ok) begin
            w0_q  <= build_header(bus.tx_pkt_type, pkt_len(bus.tx_pkt_type));
            w1_q  <= myNodeID;
            w2_q  <= bus.tx_dest_id;
            w3_q  <= w3_d;
            w4_q  <= w4_d;
            len_q <= pkt_len(bus.tx_pkt_type);
            ts_q  <= timeslot;
            idx_q <= '0;
         end else if (hs) begin
            idx_q <= is_last ? 3'd0 : idx_q + 3'd1;
         end
      end
   end

   // Word select for the current index
   always_comb begin
      word_d = '0;
      case (idx_q)
         3'd0:    word_d = w0_q;
         3'd1:    word_d = w1_q;
         3'd2:    word_d = w2_q;
         3'd3:    word_d = w3_q;
         3'd4:    word_d = w4_q;
         default: word_d = '0;
      endcase
   end

   assign bus.tx_valid = valid;
   assign bus.tx_word  = word_d;
   assign bus.tx_last  = valid && is_last;
   assign bus.tx_busy  = (state_q != ST_IDLE);
   assign bus.tx_ack   = ack_q;
   assign bus.tx_err   = err_q;
   assign bus.tx_done  = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_pkt_tx_builder.sv
// Bench for pkt_tx_builder: vector table, hand-written corner sequences and
// randomized packets scored against a word-level packet model.
module tb_pkt_tx_builder;
   import eer_pkt_pkg::*;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [15:0] myNodeID, hopsFromSink, myQValue, energy, timeslot;
   logic        role, frame_start;
   tx_state_t   dbg_state;

   pkt_tx_builder_if bus();

   pkt_tx_builder #(.SLOT_CYCLES(SC), .WORD_WIDTH(16)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .bus          (bus),
      .myNodeID     (myNodeID),
      .hopsFromSink (hopsFromSink),
      .myQValue     (myQValue),
      .energy       (energy),
      .timeslot     (timeslot),
      .role         (role),
      .frame_start  (frame_start),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [2:0]  typ;
      logic [15:0] hops, q, en, dest, pay;
      logic        role;
      int          mode;
      logic [15:0] exp_first, exp_last;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: header, source, destination, then the type's fields
   function automatic int model_pkt(input logic [2:0] t, input logic [15:0] node, dest, pay,
                                    hops, q, en);
      logic [15:0] f[$];
      int          len;
      case (t)
         3'b000: f.push_back((hops == 16'hFFFF) ? hops : hops + 16'd1);
         3'b001: begin f.push_back(q); f.push_back(en); end
         3'b100: f.push_back(pay);
         3'b101: begin f.push_back(hops); f.push_back(pay); end
         3'b110: f.push_back(en);
         default: return 0;
      endcase
      len = 3 + f.size();
      exp_q.push_back({t, 5'b0, 8'(len)});
      exp_q.push_back(node);
      exp_q.push_back(dest);
      foreach (f[i]) exp_q.push_back(f[i]);
      return len;
   endfunction

   // Consume one packet starting in the current cycle; mode 0: ready=1,
   // mode 1: ready every third cycle, mode 2: random ready + input churn
   task automatic collect(input int len, input int mode, input string name,
                          output logic [15:0] got_first, output logic [15:0] got_last);
      int          hs, c;
      logic        pv, pr, pl;
      logic [15:0] pw, e;
      hs = 0; c = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pw = '0;
      got_first = '0; got_last = '0;
      while (hs < len && c < 200) begin
         if (mode == 0)      bus.tx_ready = 1'b1;
         else if (mode == 1) bus.tx_ready = (c % 3 == 0);
         else                bus.tx_ready = 1'($urandom_range(0, 1));
         if (mode == 2) begin
            myNodeID       = 16'($urandom);
            hopsFromSink   = 16'($urandom);
            myQValue       = 16'($urandom);
            energy         = 16'($urandom);
            bus.tx_dest_id = 16'($urandom);
            bus.tx_payload = 16'($urandom);
         end
         if (c > 0) check({name, "_ack_pulse"}, bus.tx_ack, 0);
         if (pv && !pr) begin
            check({name, "_hold_valid"}, bus.tx_valid, 1);
            check({name, "_hold_word"}, bus.tx_word, pw);
            check({name, "_hold_last"}, bus.tx_last, pl);
         end
         if (bus.tx_valid && bus.tx_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            check({name, "_word"}, bus.tx_word, e);
            check({name, "_last"}, bus.tx_last, exp_q.size() == 0);
            if (hs == 0) got_first = bus.tx_word;
            got_last = bus.tx_word;
            hs++;
         end
         pv = bus.tx_valid; pr = bus.tx_ready; pw = bus.tx_word; pl = bus.tx_last;
         step();
         c++;
      end
      check({name, "_handshakes"}, hs, len);
      check({name, "_done"}, bus.tx_done, 1);
      check({name, "_idle_valid"}, bus.tx_valid, 0);
      check({name, "_idle_busy"}, bus.tx_busy, 0);
      exp_q.delete();
   endtask

   // Driver: one request, ack checks, optional slot wait, then the packet
   task automatic do_request(input logic [2:0] t, input logic [15:0] dest, input logic [15:0] pay,
                             input int mode, input int exp_wait, input string name,
                             output logic [15:0] got_first, output logic [15:0] got_last);
      int len, n;
      len = model_pkt(t, myNodeID, dest, pay, hopsFromSink, myQValue, energy);
      bus.tx_pkt_type = t;
      bus.tx_dest_id  = dest;
      bus.tx_payload  = pay;
      bus.tx_req      = 1'b1;
      step();
      bus.tx_req = 1'b0;
      check({name, "_ack"}, bus.tx_ack, 1);
      check({name, "_busy"}, bus.tx_busy, 1);
      n = 0;
      while (!bus.tx_valid && n < 200) begin
         check({name, "_wait_busy"}, bus.tx_busy, 1);
         bus.tx_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check({name, "_wait_cycles"}, n, exp_wait);
      collect(len, mode, name, got_first, got_last);
      step();
      check({name, "_done_pulse"}, bus.tx_done, 0);
   endtask

   task automatic do_reject(input logic [2:0] t, input string name);
      bus.tx_pkt_type = t;
      bus.tx_req      = 1'b1;
      step();
      bus.tx_req = 1'b0;
      check({name, "_err"}, bus.tx_err, 1);
      check({name, "_ack"}, bus.tx_ack, 0);
      check({name, "_busy"}, bus.tx_busy, 0);
      check({name, "_valid"}, bus.tx_valid, 0);
      step();
      check({name, "_err_pulse"}, bus.tx_err, 0);
      check({name, "_valid2"}, bus.tx_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] f, l;
      int          len;

      vecs[0] = '{3'b000, 16'h0003, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0004, 16'h0004};
      vecs[1] = '{3'b000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0004, 16'hFFFF};
      vecs[2] = '{3'b001, 16'h0003, 16'h1234, 16'h0200, 16'h0042, 16'h0000, 1'b1, 1, 16'h2005, 16'h0200};
      vecs[3] = '{3'b100, 16'h0003, 16'h0000, 16'h0000, 16'h0009, 16'h0007, 1'b0, 2, 16'h8004, 16'h0007};
      vecs[4] = '{3'b101, 16'h0005, 16'h0000, 16'h0000, 16'h0001, 16'hBEEF, 1'b1, 0, 16'hA005, 16'hBEEF};
      vecs[5] = '{3'b110, 16'h0003, 16'h0000, 16'h0033, 16'h0002, 16'h0000, 1'b0, 2, 16'hC004, 16'h0033};

      // reset with random inputs
      nrst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         myNodeID = 16'($urandom); hopsFromSink = 16'($urandom); myQValue = 16'($urandom);
         energy = 16'($urandom); timeslot = 16'($urandom);
         role = 1'($urandom_range(0, 1)); frame_start = 1'($urandom_range(0, 1));
         bus.tx_req = 1'($urandom_range(0, 1)); bus.tx_pkt_type = 3'($urandom_range(0, 7));
         bus.tx_dest_id = 16'($urandom); bus.tx_payload = 16'($urandom);
         bus.tx_ready = 1'($urandom_range(0, 1));
         step();
         check("rst_ack", bus.tx_ack, 0);
         check("rst_err", bus.tx_err, 0);
         check("rst_busy", bus.tx_busy, 0);
         check("rst_valid", bus.tx_valid, 0);
         check("rst_last", bus.tx_last, 0);
         check("rst_done", bus.tx_done, 0);
         check("rst_word", bus.tx_word, 0);
         check("rst_state", 32'(dbg_state), 0);
      end
      bus.tx_req = 1'b0; frame_start = 1'b0; timeslot = 16'h0009;
      nrst = 1'b1;
      step();
      check("post_rst_busy", bus.tx_busy, 0);
      check("post_rst_valid", bus.tx_valid, 0);

      // vector table
      myNodeID = 16'h000C;
      for (int i = 0; i < 6; i++) begin
         myNodeID = 16'h000C;
         hopsFromSink = vecs[i].hops; myQValue = vecs[i].q; energy = vecs[i].en;
         role = vecs[i].role;
         do_request(vecs[i].typ, vecs[i].dest, vecs[i].pay, vecs[i].mode, 0,
                    $sformatf("vec%0d", i), f, l);
         check($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
         check($sformatf("vec%0d_lastword", i), l, vecs[i].exp_last);
      end

      // member DATA held until its slot: slot_cnt reaches ts after ts*SC
      // edges past the clear, SEND follows one edge later, accept was edge 1
      myNodeID = 16'h000C; hopsFromSink = 16'h0003; role = 1'b0; timeslot = 16'd2;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      do_request(3'b101, 16'h0021, 16'h5A5A, 0, 2 * SC, "data_member", f, l);
      check("data_member_first", f, 16'hA005);
      check("data_member_lastword", l, 16'h5A5A);

      // unsupported types
      role = 1'b1;
      do_reject(3'b011, "rej011");
      do_reject(3'b010, "rej010");
      do_reject(3'b111, "rej111");

      // request while busy is ignored, then taken once idle
      myNodeID = 16'h000C; hopsFromSink = 16'h0003;
      len = model_pkt(3'b000, myNodeID, 16'h0055, 16'h0000, hopsFromSink, myQValue, energy);
      bus.tx_pkt_type = 3'b000; bus.tx_dest_id = 16'h0055; bus.tx_req = 1'b1;
      step();
      check("busy_hb_ack", bus.tx_ack, 1);
      bus.tx_pkt_type = 3'b110; energy = 16'h0077;
      collect(len, 1, "busy_hb", f, l);
      check("busy_hb_lastword", l, 16'h0004);
      check("busy_sos_not_yet", bus.tx_ack, 0);
      step();
      bus.tx_req = 1'b0;
      check("busy_sos_ack", bus.tx_ack, 1);
      len = model_pkt(3'b110, myNodeID, 16'h0055, bus.tx_payload, hopsFromSink, myQValue, energy);
      collect(len, 0, "busy_sos", f, l);
      check("busy_sos_first", f, 16'hC004);
      step();

      // reset in the middle of a CHE packet
      myQValue = 16'h1234; energy = 16'h0200;
      len = model_pkt(3'b001, myNodeID, 16'h0042, 16'h0000, hopsFromSink, myQValue, energy);
      bus.tx_ready = 1'b1; bus.tx_pkt_type = 3'b001; bus.tx_dest_id = 16'h0042; bus.tx_req = 1'b1;
      step();
      bus.tx_req = 1'b0;
      step();
      step();
      check("rst_mid_word2", bus.tx_word, 16'h0042);
      nrst = 1'b0;
      #1;
      check("rst_mid_valid", bus.tx_valid, 0);
      check("rst_mid_busy", bus.tx_busy, 0);
      check("rst_mid_last", bus.tx_last, 0);
      exp_q.delete();
      step();
      nrst = 1'b1;
      step();
      hopsFromSink = 16'h0003;
      do_request(3'b000, 16'hFFFF, 16'h0000, 0, 0, "after_rst_hb", f, l);
      check("after_rst_first", f, 16'h0004);
      check("after_rst_lastword", l, 16'h0004);

      // randomized packets
      for (int i = 0; i < 24; i++) begin
         logic [2:0] t;
         t = 3'($urandom_range(0, 7));
         myNodeID = 16'($urandom); hopsFromSink = 16'($urandom);
         myQValue = 16'($urandom); energy = 16'($urandom);
         role = ($urandom_range(0, 1) == 1) || (t == 3'b101);
         if (t == 3'b010 || t == 3'b011 || t == 3'b111)
            do_reject(t, "rand_rej");
         else
            do_request(t, 16'($urandom), 16'($urandom), 2, 0, "rand", f, l);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
